// File: rtl/ber_checker.sv
// rtl/ber_checker.sv - Symbol BER checker with automatic latency search and windowed error count.
// Optional lock-loss relock is enabled by defining BER_RELOCK_EN.
module ber_checker #(
    parameter int MAX_DELAY   = 32,
    parameter int ALIGN_SYMS  = 64,
    parameter int MEAS_LOG2   = 20,
    parameter int ERR_W       = 24
`ifdef BER_RELOCK_EN
    ,
    parameter int LOSS_THRESH = 16
`endif
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         sym_clk_ena,
    input  logic                         clear,
    input  logic [1:0]                   ref_i,
    input  logic [1:0]                   ref_q,
    input  logic [1:0]                   rx_i,
    input  logic [1:0]                   rx_q,
    output logic                         locked,
    output logic [$clog2(MAX_DELAY)-1:0] delay,
    output logic [ERR_W-1:0]             err_result,
    output logic                         meas_done
);

    localparam int DW = $clog2(MAX_DELAY);
    localparam int MW = $clog2(ALIGN_SYMS);
    localparam logic [DW-1:0] FILL_LAST  = DW'(MAX_DELAY - 1);
    localparam logic [MW-1:0] MATCH_LAST = MW'(ALIGN_SYMS - 1);

    typedef enum logic [1:0] {S_FILL, S_SEARCH, S_LOCKED} state_t;

    state_t               state_q;
    logic [3:0]           mem_q [MAX_DELAY];
    logic [DW-1:0]        wp_q;
    logic [DW-1:0]        fill_q;
    logic [DW-1:0]        delay_q;
    logic [MW-1:0]        match_q;
    logic [MEAS_LOG2-1:0] sym_cnt_q;
    logic [ERR_W-1:0]     acc_q;
    logic [ERR_W-1:0]     err_result_q;
    logic                 locked_q;
    logic                 meas_done_q;

    logic [3:0]           ref_sym;
    logic [3:0]           dly_ref;
    logic [3:0]           err_bits;
    logic [2:0]           pop;
    logic                 mismatch;
    logic [DW-1:0]        rd_ptr;
    logic [ERR_W:0]       acc_sum;
    logic [ERR_W-1:0]     acc_d;
    logic                 sym_last;

    // Entry written d enables ago sits at wp-d; d=0 bypasses the buffer.
    assign ref_sym  = {ref_i, ref_q};
    assign rd_ptr   = wp_q - delay_q;
    assign dly_ref  = (delay_q == '0) ? ref_sym : mem_q[rd_ptr];
    assign err_bits = {rx_i, rx_q} ^ dly_ref;
    assign pop      = 3'(err_bits[0]) + 3'(err_bits[1]) + 3'(err_bits[2]) + 3'(err_bits[3]);
    assign mismatch = |err_bits;
    assign acc_sum  = {1'b0, acc_q} + {{(ERR_W-2){1'b0}}, pop};
    assign acc_d    = acc_sum[ERR_W] ? '1 : acc_sum[ERR_W-1:0];
    assign sym_last = &sym_cnt_q;

`ifdef BER_RELOCK_EN
    localparam int SW = $clog2(ALIGN_SYMS + 1);
    localparam logic [SW-1:0] THRESH = SW'(LOSS_THRESH);
    logic [MW-1:0] blk_q;
    logic [SW-1:0] miss_q;
    logic [SW-1:0] miss_d;
    logic          loss;
    assign miss_d = miss_q + SW'(mismatch);
    assign loss   = miss_d > THRESH;
`endif

    always_ff @(posedge clk) begin
        if (reset && !clear && sym_clk_ena) begin
            mem_q[wp_q] <= ref_sym;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_FILL;
            wp_q         <= '0;
            fill_q       <= '0;
            delay_q      <= '0;
            match_q      <= '0;
            sym_cnt_q    <= '0;
            acc_q        <= '0;
            err_result_q <= '0;
            locked_q     <= 1'b0;
            meas_done_q  <= 1'b0;
`ifdef BER_RELOCK_EN
            blk_q        <= '0;
            miss_q       <= '0;
`endif
        end else begin
            meas_done_q <= 1'b0;
            if (clear) begin
                state_q      <= S_SEARCH;
                delay_q      <= '0;
                match_q      <= '0;
                sym_cnt_q    <= '0;
                acc_q        <= '0;
                err_result_q <= '0;
                locked_q     <= 1'b0;
`ifdef BER_RELOCK_EN
                blk_q        <= '0;
                miss_q       <= '0;
`endif
            end else if (sym_clk_ena) begin
                wp_q <= wp_q + DW'(1);
                case (state_q)
                    S_FILL: begin
                        fill_q <= fill_q + DW'(1);
                        if (fill_q == FILL_LAST) begin
                            state_q <= S_SEARCH;
                            delay_q <= '0;
                            match_q <= '0;
                        end
                    end
                    S_SEARCH: begin
                        if (mismatch) begin
                            delay_q <= delay_q + DW'(1);
                            match_q <= '0;
                        end else if (match_q == MATCH_LAST) begin
                            state_q   <= S_LOCKED;
                            locked_q  <= 1'b1;
                            match_q   <= '0;
                            sym_cnt_q <= '0;
                            acc_q     <= '0;
`ifdef BER_RELOCK_EN
                            blk_q     <= '0;
                            miss_q    <= '0;
`endif
                        end else begin
                            match_q <= match_q + MW'(1);
                        end
                    end
                    S_LOCKED: begin
                        sym_cnt_q <= sym_cnt_q + MEAS_LOG2'(1);
                        if (sym_last) begin
                            err_result_q <= acc_d;
                            meas_done_q  <= 1'b1;
                            acc_q        <= '0;
                        end else begin
                            acc_q <= acc_d;
                        end
`ifdef BER_RELOCK_EN
                        // Block bookkeeping; a loss overrides the window update above.
                        blk_q  <= (blk_q == MATCH_LAST) ? '0 : blk_q + MW'(1);
                        miss_q <= (blk_q == MATCH_LAST) ? '0 : miss_d;
                        if (loss) begin
                            state_q      <= S_SEARCH;
                            locked_q     <= 1'b0;
                            delay_q      <= delay_q + DW'(1);
                            match_q      <= '0;
                            sym_cnt_q    <= '0;
                            acc_q        <= '0;
                            err_result_q <= err_result_q;
                            meas_done_q  <= 1'b0;
                            blk_q        <= '0;
                            miss_q       <= '0;
                        end
`endif
                    end
                    default: state_q <= S_FILL;
                endcase
            end
        end
    end

    assign locked     = locked_q;
    assign delay      = delay_q;
    assign err_result = err_result_q;
    assign meas_done  = meas_done_q;

endmodule

// File: tb/tb_ber_checker.sv
// tb/tb_ber_checker.sv - Self-checking bench for ber_checker against a symbol-level reference model.
`timescale 1ns/1ps
module tb_ber_checker;
    localparam int MAX_DELAY  = 32;
    localparam int ALIGN_SYMS = 64;
    localparam int MEAS_LOG2  = 12;
    localparam int ERR_W      = 24;
    localparam int WIN        = 1 << MEAS_LOG2;
`ifdef BER_RELOCK_EN
    localparam int LOSS_THRESH = 16;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             sym_clk_ena = 1'b0;
    logic             clear = 1'b0;
    logic [1:0]       ref_i = '0, ref_q = '0, rx_i = '0, rx_q = '0;
    logic             locked;
    logic [4:0]       delay;
    logic [ERR_W-1:0] err_result;
    logic             meas_done;

    ber_checker #(
        .MAX_DELAY (MAX_DELAY),
        .ALIGN_SYMS(ALIGN_SYMS),
        .MEAS_LOG2 (MEAS_LOG2),
        .ERR_W     (ERR_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sym_clk_ena(sym_clk_ena),
        .clear      (clear),
        .ref_i      (ref_i),
        .ref_q      (ref_q),
        .rx_i       (rx_i),
        .rx_q       (rx_q),
        .locked     (locked),
        .delay      (delay),
        .err_result (err_result),
        .meas_done  (meas_done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int n_print = 0;

    // Reference model: phase 0 fill, 1 search, 2 locked; history[0] is the newest ref symbol.
    int         m_phase = 0, m_fill = 0, m_run = 0, m_d = 0;
    int         m_acc = 0, m_cnt = 0, m_err = 0, m_blk = 0, m_miss = 0, m_bits = 0;
    bit         m_locked = 1'b0, m_done = 1'b0;
    logic [3:0] m_hist[$];

    always @(posedge clk) begin
        m_done = 1'b0;
        if (!reset) begin
            m_phase = 0; m_fill = 0; m_run = 0; m_d = 0; m_acc = 0; m_cnt = 0;
            m_err = 0; m_locked = 1'b0; m_blk = 0; m_miss = 0;
            m_hist.delete();
        end else if (clear) begin
            m_phase = 1; m_run = 0; m_d = 0; m_acc = 0; m_cnt = 0; m_err = 0;
            m_locked = 1'b0; m_blk = 0; m_miss = 0;
        end else if (sym_clk_ena) begin
            m_hist.push_front({ref_i, ref_q});
            if (m_hist.size() > MAX_DELAY) void'(m_hist.pop_back());
            m_bits = (m_d < m_hist.size()) ? $countones({rx_i, rx_q} ^ m_hist[m_d]) : 0;
            if (m_phase == 0) begin
                m_fill++;
                if (m_fill == MAX_DELAY) begin m_phase = 1; m_d = 0; m_run = 0; end
            end else if (m_phase == 1) begin
                if (m_bits != 0) begin
                    m_d = (m_d + 1) % MAX_DELAY;
                    m_run = 0;
                end else begin
                    m_run++;
                    if (m_run == ALIGN_SYMS) begin
                        m_phase = 2; m_locked = 1'b1; m_acc = 0; m_cnt = 0; m_run = 0;
                        m_blk = 0; m_miss = 0;
                    end
                end
            end else begin
`ifdef BER_RELOCK_EN
                m_blk++;
                if (m_bits != 0) m_miss++;
                if (m_miss > LOSS_THRESH) begin
                    m_phase = 1; m_locked = 1'b0; m_d = (m_d + 1) % MAX_DELAY;
                    m_acc = 0; m_cnt = 0; m_run = 0; m_blk = 0; m_miss = 0;
                end else begin
                    if (m_blk == ALIGN_SYMS) begin m_blk = 0; m_miss = 0; end
`endif
                    m_acc = m_acc + m_bits;
                    if (m_acc > (1 << ERR_W) - 1) m_acc = (1 << ERR_W) - 1;
                    m_cnt++;
                    if (m_cnt == WIN) begin
                        m_err = m_acc; m_done = 1'b1; m_acc = 0; m_cnt = 0;
                    end
`ifdef BER_RELOCK_EN
                end
`endif
            end
        end
        #1;
        n_vec++;
        if (locked !== m_locked || delay !== m_d[4:0] || err_result !== m_err[ERR_W-1:0]
            || meas_done !== m_done) begin
            n_bad++;
            if (n_print < 20) begin
                n_print++;
                $display("FAIL model_cycle t=%0t: dut locked=%b delay=%0d err=%0d done=%b required locked=%b delay=%0d err=%0d done=%b",
                         $time, locked, delay, err_result, meas_done, m_locked, m_d, m_err, m_done);
            end
        end
    end

    task automatic expect_val(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    // Channel: PRBS23 reference, rx is the reference delayed by ch_delay enables.
    logic [22:0] lfsr = 23'h7FFFFF;
    logic [3:0]  chan[$];
    int          ch_delay = 7;

    task automatic send(input logic [3:0] flip);
        logic [3:0] s, r;
        logic       fb;
        @(negedge clk);
        s = '0;
        for (int k = 0; k < 4; k++) begin
            fb   = lfsr[22] ^ lfsr[17];
            lfsr = {lfsr[21:0], fb};
            s    = {s[2:0], fb};
        end
        chan.push_front(s);
        if (chan.size() > 64) void'(chan.pop_back());
        r = (chan.size() > ch_delay) ? chan[ch_delay] : 4'h0;
        r = r ^ flip;
        {ref_i, ref_q} = s;
        {rx_i, rx_q}   = r;
        sym_clk_ena    = 1'b1;
        clear          = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
        sym_clk_ena = 1'b0;
        clear       = 1'b0;
    endtask

    task automatic wait_lock(input string name, output int n_syms);
        n_syms = 0;
        for (int k = 0; k < 3000; k++) begin
            send(4'h0);
            n_syms++;
            @(posedge clk); #2;
            if (locked === 1'b1) break;
        end
        expect_val({name, " locked"}, longint'(locked), 1);
        expect_val({name, " delay"}, longint'(delay), ch_delay);
    endtask

    // mode 0 clean, 1 one bit flip per 1024, 2 ten all-bit inversions, 3 clean with enable gaps
    task automatic run_window(input string name, input int mode, input int lo, input int hi);
        logic [3:0] f;
        for (int i = 0; i < WIN; i++) begin
            f = 4'h0;
            if (mode == 1 && (i % 1024) == 100) f = 4'(1 << (i / 1024));
            if (mode == 2 && i >= 500 && i < 510) f = 4'hF;
            if (mode == 3 && (i % 5) == 4) idle();
            send(f);
        end
        @(posedge clk); #2;
        expect_val({name, " meas_done"}, longint'(meas_done), 1);
        if (lo == hi) expect_val({name, " err_result"}, longint'(err_result), lo);
        else expect_val({name, " err_result in range"},
                        longint'(err_result >= ERR_W'(lo) && err_result <= ERR_W'(hi)), 1);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #2;
        expect_val("reset locked", longint'(locked), 0);
        expect_val("reset delay", longint'(delay), 0);
        expect_val("reset err_result", longint'(err_result), 0);
        expect_val("reset meas_done", longint'(meas_done), 0);
        @(negedge clk);
        reset = 1'b1;

        wait_lock("initial lock", n);
        expect_val("initial lock includes fill", longint'(n >= MAX_DELAY + 7 + ALIGN_SYMS), 1);
        run_window("window clean", 0, 0, 0);
        run_window("window gapped", 3, 0, 0);
        run_window("window single flips", 1, 4, 4);
        run_window("window burst", 2, 40, 40);
        expect_val("burst keeps lock", longint'(locked), 1);

        for (int i = 0; i < 1000; i++) send(4'h0);
        @(negedge clk);
        clear = 1'b1; sym_clk_ena = 1'b1;
        {ref_i, ref_q} = 4'h5; {rx_i, rx_q} = 4'hA;
        @(posedge clk); #2;
        expect_val("clear locked", longint'(locked), 0);
        expect_val("clear err_result", longint'(err_result), 0);
        expect_val("clear delay", longint'(delay), 0);
        wait_lock("clear relock", n);
        expect_val("clear relock skips fill", longint'(n < MAX_DELAY + 7 + ALIGN_SYMS), 1);

        for (int i = 0; i < 500; i++) send(4'h0);
        @(negedge clk);
        reset = 1'b0; sym_clk_ena = 1'b0;
        @(posedge clk); #2;
        expect_val("midrun reset locked", longint'(locked), 0);
        expect_val("midrun reset delay", longint'(delay), 0);
        expect_val("midrun reset err_result", longint'(err_result), 0);
        @(negedge clk);
        reset = 1'b1;
        wait_lock("reset relock", n);
        expect_val("reset relock includes fill", longint'(n >= MAX_DELAY + 7 + ALIGN_SYMS), 1);

        ch_delay = 12;
`ifdef BER_RELOCK_EN
        for (int i = 0; i < ALIGN_SYMS; i++) begin
            send(4'h0);
            @(posedge clk); #2;
            if (locked === 1'b0) break;
        end
        expect_val("delay change drops lock", longint'(locked), 0);
        wait_lock("delay change relock", n);
`else
        run_window("delay change window", 0, 2 * WIN - 700, 2 * WIN + 700);
        expect_val("delay change keeps lock", longint'(locked), 1);
`endif

        idle();
        repeat (3) @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/ber_checker.md
# ber_checker

Symbol-level bit-error-rate checker for the 16-QAM modem chain. It sits beside the receiver and compares recovered I/Q symbols against the 2-bit symbols fed to the transmitter. A delay line and search state machine find the end-to-end symbol latency automatically. Once locked, it counts bit errors over fixed measurement windows and latches one result per window.

## Interface
- MAX_DELAY, 32: depth of the reference delay line in symbols; power of 2; searchable latency is 0..MAX_DELAY-1.
- ALIGN_SYMS, 64: consecutive error-free symbols required to declare lock; also the lock-loss block length.
- MEAS_LOG2, 20: measurement window is 2^MEAS_LOG2 symbols.
- ERR_W, 24: width of the error accumulator and result.
- LOSS_THRESH, 16: symbol mismatches per ALIGN_SYMS block that trigger a relock; used only with BER_RELOCK_EN.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: synchronous, active-low.
- sym_clk_ena, in, 1: symbol-rate enable. All state advances only on clk edges where this is 1, except reset, clear and the meas_done clear.
- clear, in, 1: synchronous, active-high restart of measurement.
- ref_i, ref_q, in, 2 each: transmitted symbols (lfsr outputs).
- rx_i, rx_q, in, 2 each: receiver symbol decisions.
- locked, out, 1: alignment found.
- delay, out, log2(MAX_DELAY): current candidate or locked latency.
- err_result, out, ERR_W: bit errors in the last completed window.
- meas_done, out, 1: one-clk pulse when err_result updates.

## Operation
- Delay line: circular buffer of MAX_DELAY entries, 4 bits each ({ref_i,ref_q}). Written at wp on every sym_clk_ena; wp then increments mod MAX_DELAY.
  - Delayed reference for delay d is the ref input from d enables earlier.
  - d=0 selects the current input directly.
- Per-symbol bit errors: popcount({rx_i,rx_q} XOR delayed ref), range 0..4. A symbol mismatch is any non-zero popcount.
- States:
  - FILL: count MAX_DELAY enables, then go to SEARCH with d=0. No comparisons occur in FILL.
  - SEARCH: match counter counts consecutive symbols with no mismatch.
    - On a mismatch: d = (d+1) mod MAX_DELAY and the match counter resets to 0.
    - When the match counter reaches ALIGN_SYMS: go to LOCKED with locked=1 and window counters zeroed.
  - LOCKED: each enable adds the popcount to the accumulator and increments the symbol counter.
    - The accumulator saturates at 2^ERR_W-1.
    - On the 2^MEAS_LOG2-th symbol: err_result is loaded with the accumulator including that symbol's errors, meas_done pulses, and both counters restart at 0.
- clear (in any state): go to SEARCH with d=0, locked=0, accumulator=0, err_result=0, meas_done=0. The buffer is kept and FILL is not repeated.
  - If clear and sym_clk_ena are both high, clear wins and that symbol is neither written nor compared.
- Constant or low-entropy reference data can lock at a wrong delay. The bench must drive PRBS data.

## Timing
- Reset values: locked=0, delay=0, err_result=0, meas_done=0, state FILL, wp=0, all counters 0.
- Reset applies on the first clk edge with reset=0, mid-operation included. Outputs are at reset values in the following cycle.
- All outputs are registered.
- meas_done goes high on the same edge as the final window enable and is cleared on the next clk edge, regardless of enable.
- locked rises on the edge that processes the ALIGN_SYMS-th consecutive match.
- delay changes on the edge of the mismatching enable.
- Latency from rx input to its error being in the accumulator: 1 clk.

## Configuration
- BER_RELOCK_EN defined:
  - LOCKED also counts symbol mismatches per consecutive ALIGN_SYMS-symbol block.
  - If the count exceeds LOSS_THRESH within a block: locked=0, state SEARCH, d=(d+1) mod MAX_DELAY, accumulator zeroed, err_result held.
- BER_RELOCK_EN undefined:
  - No lock-loss logic.
  - LOCKED exits only via reset or clear.

## Test plan
- PRBS ref, rx = ref delayed 7 symbols, no errors, MEAS_LOG2=12 -> locked=1 with delay=7; every 4096 symbols meas_done pulses with err_result=0.
- Same setup, one rx bit flipped every 1024 symbols -> err_result=4 each window.
- After lock, all 4 rx bits inverted for 10 consecutive symbols -> err_result=40 for that window; locked stays 1 with BER_RELOCK_EN undefined.
- clear asserted together with sym_clk_ena mid-window -> next cycle locked=0, err_result=0, delay=0; relocks at delay=7 with no FILL phase.
- reset=0 for one edge while locked -> all outputs at reset values; relock only after MAX_DELAY fill symbols.
- Channel delay changed from 7 to 12 after lock:
  - BER_RELOCK_EN defined: locked drops within 64 symbols and relocks with delay=12.
  - BER_RELOCK_EN undefined: locked stays 1 and err_result is about 2^MEAS_LOG2*2.
